// File: rtl/intra_tap_accumulator.sv
// Serial tap accumulator for the intra angular prediction datapath.
// Sums up to MAX_TAPS signed coefficient x sample products per predicted
// sample, then rounds, arithmetically shifts and clips the total into an
// unsigned OUT_W-bit sample held on a valid/ready output slot.
module intra_tap_accumulator #(
    parameter int IN_W     = 16,
    parameter int MAX_TAPS = 4,
    parameter int SHIFT    = 4,
    parameter int OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sample,
    output logic             tap_err,
    input  logic             err_clr
);

    // Counter is at least one bit wide so a single-tap configuration still builds.
    localparam int CNT_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

    // One extra bit of headroom per doubling of taps plus a sign guard bit.
    localparam int ACC_W = IN_W + $clog2(MAX_TAPS) + 1;

    localparam logic [CNT_W-1:0]        LAST_IDX   = CNT_W'(MAX_TAPS - 1);
    localparam logic signed [ACC_W-1:0] ROUND      = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAMPLE_MAX = ACC_W'((2 ** OUT_W) - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]         tap_cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     out_valid_nxt;
    logic [OUT_W-1:0]         out_sample_nxt;
    logic                     tap_err_nxt;

    logic                     accept;
    logic                     at_last_slot;
    logic                     final_tap;
    logic                     forced_end;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  res;
    logic [OUT_W-1:0]         clipped;

    // Taps may flow whenever the output slot is empty or is draining this cycle.
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign at_last_slot = (tap_cnt == LAST_IDX);
    assign final_tap    = in_last || at_last_slot;
    assign forced_end   = accept && at_last_slot && !in_last;

    // Round, floor-shift and clip the completed sum of the current sample.
    always_comb begin
        prod_ext = {{(ACC_W - IN_W){in_prod[IN_W-1]}}, in_prod};
        sum      = acc + prod_ext + ROUND;
        res      = sum >>> SHIFT;
        clipped  = '0;
        if (res[ACC_W-1]) begin
            clipped = '0;
        end else if (res > SAMPLE_MAX) begin
            clipped = SAMPLE_MAX[OUT_W-1:0];
        end else begin
            clipped = res[OUT_W-1:0];
        end
    end

    // Accumulation FSM: IDLE with an empty sum, ACCUM while a partial sum is held.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = tap_cnt;
        if (accept) begin
            if (final_tap) begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end else begin
                state_nxt = ACCUM;
                acc_nxt   = acc + prod_ext;
                cnt_nxt   = tap_cnt + 1'b1;
            end
        end
    end

    // Output slot: a finishing tap reloads it, otherwise a handshake empties it.
    always_comb begin
        out_valid_nxt  = out_valid;
        out_sample_nxt = out_sample;
        if (accept && final_tap) begin
            out_valid_nxt  = 1'b1;
            out_sample_nxt = clipped;
        end else if (out_valid && out_ready) begin
            out_valid_nxt  = 1'b0;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_comb begin
        tap_err_nxt = tap_err;
        if (forced_end) begin
            tap_err_nxt = 1'b1;
        end else if (err_clr) begin
            tap_err_nxt = 1'b0;
        end
    end

    // State, partial sum and tap count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            tap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            tap_cnt <= cnt_nxt;
        end
    end

    // Output slot and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            tap_err    <= 1'b0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_sample <= out_sample_nxt;
            tap_err    <= tap_err_nxt;
        end
    end

endmodule

// File: tb/tb_intra_tap_accumulator.sv
// Self-checking bench for intra_tap_accumulator: a vector table of whole
// filters plus hand-written backpressure, overrun, drain and reset sequences.
// Expected samples go into a scoreboard queue when a filter is driven and
// are compared as the output handshake completes.
module tb_intra_tap_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sample;
    logic        tap_err;
    logic        err_clr;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;

    logic [7:0] exp_q[$];
    int         hs_cycles[$];

    typedef struct {
        int          ntaps;
        logic [15:0] prod [4];
        logic [7:0]  exp_sample;
    } vec_t;

    vec_t vecs[10];

    intra_tap_accumulator #(
        .IN_W(16), .MAX_TAPS(4), .SHIFT(4), .OUT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_prod(in_prod),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sample(out_sample),
        .tap_err(tap_err),
        .err_clr(err_clr)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure spacing between output handshakes.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one tap and hold it until the DUT accepts it, bounded at 50 cycles.
    task automatic applyStimulus(input logic [15:0] prod, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL tap_accept_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic setVec(input int idx, input int n, input int p0, input int p1,
                          input int p2, input int p3, input int e);
        vecs[idx].ntaps      = n;
        vecs[idx].prod[0]    = 16'(p0);
        vecs[idx].prod[1]    = 16'(p1);
        vecs[idx].prod[2]    = 16'(p2);
        vecs[idx].prod[3]    = 16'(p3);
        vecs[idx].exp_sample = 8'(e);
    endtask

    // Scoreboard: every completed output handshake pops one expected sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_sample: got %0d, expected no output", out_sample);
            end else begin
                checkOutput("sample", 32'(out_sample), 32'(exp_q.pop_front()));
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        setVec(0, 4,   -4, 144, 48, -8,  11);
        setVec(1, 4,  -40,   0,  0,  0,   0);
        setVec(2, 1, 4200,   0,  0,  0, 255);
        setVec(3, 1, 4080,   0,  0,  0, 255);
        setVec(4, 2,   16,  16,  0,  0,   2);
        setVec(5, 3,  100, -20,  3,  0,   5);
        setVec(6, 1,  -17,   0,  0,  0,   0);
        setVec(7, 1,   -8,   0,  0,  0,   0);
        setVec(8, 1,   24,   0,  0,  0,   2);
        setVec(9, 1,   23,   0,  0,  0,   1);

        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_out_sample", 32'(out_sample), 0);
        checkOutput("reset_tap_err", 32'(tap_err), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-tap filter; out_valid lasts exactly one cycle when drained at once.
        exp_q.push_back(8'd11);
        applyStimulus(16'hFFFC, 1'b0);
        applyStimulus(16'd144, 1'b0);
        applyStimulus(16'd48, 1'b0);
        applyStimulus(16'hFFF8, 1'b1);
        @(negedge clk);
        checkOutput("one_cycle_valid_hi", 32'(out_valid), 1);
        @(negedge clk);
        checkOutput("one_cycle_valid_lo", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Vector table applied back to back with the output always ready.
        for (int v = 0; v < 10; v++) begin
            exp_q.push_back(vecs[v].exp_sample);
            for (int t = 0; t < vecs[v].ntaps; t++) begin
                applyStimulus(vecs[v].prod[t], (t == vecs[v].ntaps - 1));
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back 2-tap samples drain on consecutive sample boundaries.
        hs_cycles.delete();
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd4);
        applyStimulus(16'd16, 1'b0);
        applyStimulus(16'd16, 1'b1);
        applyStimulus(16'd32, 1'b0);
        applyStimulus(16'd32, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b_count", 32'(hs_cycles.size()), 2);
        if (hs_cycles.size() == 2) begin
            checkOutput("b2b_spacing", 32'(hs_cycles[1] - hs_cycles[0]), 2);
        end

        // Backpressure: slot held, input stalled, waiting taps not lost.
        out_ready = 1'b0;
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd6);
        applyStimulus(16'd16, 1'b0);
        applyStimulus(16'd16, 1'b1);
        fork
            begin
                applyStimulus(16'd48, 1'b0);
                applyStimulus(16'd48, 1'b1);
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", 32'(in_ready), 0);
                    checkOutput("bp_out_valid", 32'(out_valid), 1);
                    checkOutput("bp_out_sample", 32'(out_sample), 2);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Missing in_last: forced termination after four taps, then a new sample.
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd2);
        for (int t = 0; t < 4; t++) applyStimulus(16'd16, 1'b0);
        checkOutput("overrun_tap_err", 32'(tap_err), 1);
        applyStimulus(16'd16, 1'b0);
        applyStimulus(16'd16, 1'b1);
        checkOutput("overrun_err_sticky", 32'(tap_err), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkOutput("err_clr", 32'(tap_err), 0);

        // Overrun set wins over a clear held in the same cycle.
        exp_q.push_back(8'd4);
        err_clr = 1'b1;
        for (int t = 0; t < 4; t++) applyStimulus(16'd16, 1'b0);
        err_clr = 1'b0;
        checkOutput("set_beats_clear", 32'(tap_err), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-sample discards the partial sum.
        applyStimulus(16'd16, 1'b0);
        applyStimulus(16'd16, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(8'd2);
        applyStimulus(16'd16, 1'b0);
        applyStimulus(16'd16, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
